// File: rtl/dcnn_pkg.sv
// Shared types for the stride-1 psum collector: FSM state encoding and row parity tags.
package dcnn_pkg;

    typedef enum logic [1:0] {
        COL_IDLE  = 2'd0,
        COL_ACCUM = 2'd1,
        COL_FLUSH = 2'd2,
        COL_DONE  = 2'd3
    } col_state_e;

    localparam logic PAR_ODD  = 1'b0;
    localparam logic PAR_EVEN = 1'b1;

endpackage

// File: rtl/dcnn_sync_fifo.sv
// Show-ahead synchronous FIFO; head is presented combinationally and reads as zero when empty.
module dcnn_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push on full is fine when paired with a pop.
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !clr) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dcnn_s1_psum_collector.sv
// Accumulates chain-tail psums over input-channel passes into per-parity row buffers and queues final pixels.
// Optional DCNN_PSUM_RELU_EN clamps negative final sums to zero before they are queued.
module dcnn_s1_psum_collector
    import dcnn_pkg::*;
#(
    parameter int DW         = 16,
    parameter int M_BITS     = 10,
    parameter int ROW_BITS   = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                start,
    input  logic [ROW_BITS:0]   row_len,
    input  logic [M_BITS-1:0]   num_pass,
    input  logic [DW-1:0]       psum_in,
    input  logic [1:0]          psum_in_vld,
    output logic [DW-1:0]       out_data,
    output logic                out_parity,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic                err
);

    localparam int ROW_MAX = 1 << ROW_BITS;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    col_state_e                  r_state;
    col_state_e                  w_state_next;
    logic [ROW_BITS:0]           r_row_len;
    logic [M_BITS-1:0]           r_num_pass;
    logic [M_BITS-1:0]           r_pass;
    logic [1:0][ROW_BITS-1:0]    r_pos;
    logic [1:0]                  r_row_done;
    logic                        r_push_vld;
    logic [DW:0]                 r_push_data;
    logic                        r_ovf;
    logic                        r_err;

    logic                        w_active;
    logic                        w_par;
    logic                        w_take;
    logic [ROW_BITS-1:0]         w_pos_cur;
    logic [1:0][DW-1:0]          w_rd;
    logic [DW-1:0]               w_sum;
    logic [DW-1:0]               w_final;
    logic                        w_last_pass;
    logic                        w_pos_wrap;
    logic [1:0]                  w_done_set;
    logic                        w_row_done_all;
    logic [1:0]                  w_wr_en;
    logic                        w_pop;
    logic                        w_drop;
    logic [DW:0]                 w_fifo_rdata;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [CW-1:0]               w_fifo_count;

    assign w_active    = (r_state == COL_ACCUM) && !start;
    assign w_par       = psum_in_vld[1];
    assign w_take      = w_active && (psum_in_vld == 2'b01 || psum_in_vld == 2'b10) && !r_row_done[w_par];
    assign w_pos_cur   = r_pos[w_par];
    assign w_sum       = (r_pass == '0) ? psum_in : w_rd[w_par] + psum_in;
    assign w_last_pass = (r_pass == r_num_pass - 1'b1);
    assign w_pos_wrap  = ({1'b0, w_pos_cur} == r_row_len - 1'b1);
    assign w_done_set  = {w_take && (w_par == PAR_EVEN) && w_pos_wrap,
                          w_take && (w_par == PAR_ODD)  && w_pos_wrap};
    assign w_row_done_all = ((r_row_done | w_done_set) == 2'b11);

`ifdef DCNN_PSUM_RELU_EN
    assign w_final = w_sum[DW-1] ? '0 : w_sum;
`else
    assign w_final = w_sum;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_row_buf
            logic [DW-1:0] r_buf [ROW_MAX];
            // Only intermediate passes write back; the final pass goes straight to the FIFO.
            assign w_wr_en[gi] = w_take && (w_par == 1'(gi)) && !w_last_pass;
            assign w_rd[gi]    = r_buf[r_pos[gi]];
            always_ff @(posedge clk) begin
                if (w_wr_en[gi]) r_buf[r_pos[gi]] <= w_sum;
            end
        end
    endgenerate

    assign w_pop  = out_vld && out_rdy;
    assign w_drop = r_push_vld && w_fifo_full && !w_pop;

    dcnn_sync_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (start),
        .push   (r_push_vld),
        .wdata  (r_push_data),
        .pop    (w_pop),
        .rdata  (w_fifo_rdata),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty),
        .count  (w_fifo_count)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= COL_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = COL_ACCUM;
        end else begin
            case (r_state)
                COL_ACCUM: if (w_row_done_all && w_last_pass) w_state_next = COL_FLUSH;
                // Leave on the cycle the last entry is popped so done follows that pop directly.
                COL_FLUSH: if (!r_push_vld && (w_fifo_empty || (w_pop && w_fifo_count == CW'(1))))
                               w_state_next = COL_DONE;
                COL_DONE:  w_state_next = COL_IDLE;
                default:   w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_row_len   <= '0;
            r_num_pass  <= '0;
            r_pass      <= '0;
            r_pos       <= '0;
            r_row_done  <= '0;
            r_push_vld  <= 1'b0;
            r_push_data <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else if (start) begin
            r_row_len   <= row_len;
            r_num_pass  <= num_pass;
            r_pass      <= '0;
            r_pos       <= '0;
            r_row_done  <= '0;
            r_push_vld  <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_push_vld  <= w_take && w_last_pass;
            r_push_data <= {w_par, w_final};
            if (w_drop) r_ovf <= 1'b1;
            if (w_active && psum_in_vld == 2'b11) r_err <= 1'b1;
            if (w_take) r_pos[w_par] <= w_pos_wrap ? '0 : w_pos_cur + 1'b1;
            if (w_row_done_all) begin
                r_row_done <= '0;
                r_pass     <= r_pass + 1'b1;
            end else begin
                r_row_done <= r_row_done | w_done_set;
            end
        end
    end

    assign out_vld    = !w_fifo_empty;
    assign out_data   = w_fifo_rdata[DW-1:0];
    assign out_parity = w_fifo_rdata[DW];
    assign busy       = (r_state != COL_IDLE);
    assign done       = (r_state == COL_DONE);
    assign ovf        = r_ovf;
    assign err        = r_err;

endmodule

// File: tb/tb_dcnn_s1_psum_collector.sv
// Bench for dcnn_s1_psum_collector: table vectors, hand sequences for corner cases, randomized tiles vs. a sum model.
module tb_dcnn_s1_psum_collector;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  row_len = '0;
    logic [9:0]  num_pass = '0;
    logic [15:0] psum_in = '0;
    logic [1:0]  psum_in_vld = '0;
    logic [15:0] out_data;
    logic        out_parity;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        err;

    dcnn_s1_psum_collector dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .row_len     (row_len),
        .num_pass    (num_pass),
        .psum_in     (psum_in),
        .psum_in_vld (psum_in_vld),
        .out_data    (out_data),
        .out_parity  (out_parity),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit rand_rdy = 1'b0;
    int done_cnt = 0;
    logic [16:0] got[$];
    logic [16:0] exp_q[$];

    typedef struct {
        logic [1:0]  vld;
        logic [15:0] d;
        logic [16:0] exp;
    } vec_t;
    vec_t t1[8];

    always @(negedge clk) begin
        if (arst_n) begin
            if (out_vld && out_rdy) got.push_back({out_parity, out_data});
            if (done) done_cnt++;
        end
    end

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef DCNN_PSUM_RELU_EN
        return v[15] ? 16'h0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_rdy = ($urandom_range(0, 9) < 7);
    endtask

    task automatic smp(input logic [1:0] v, input logic [15:0] d);
        psum_in_vld = v;
        psum_in     = d;
        tick();
        psum_in_vld = 2'b00;
    endtask

    task automatic start_tile(input int rl, input int np);
        row_len  = 7'(rl);
        num_pass = 10'(np);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        got.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        tick();
        chk({name, "_done_1cyc"}, 32'(done), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic cmp_q(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_out%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            t1[2*i]   = '{2'b01, 16'(i + 1), {1'b0, 16'(i + 1)}};
            t1[2*i+1] = '{2'b10, 16'(i + 5), {1'b1, 16'(i + 5)}};
        end

        // Reset state
        #1;
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_parity", 32'(out_parity), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();

        // Table: single pass, interleaved rows, arrival order preserved
        out_rdy = 1'b1;
        start_tile(4, 1);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            smp(t1[i].vld, t1[i].d);
            if (i == 0) chk("t1_lat_n", 32'(out_vld), 32'd0);
            if (i == 1) begin
                chk("t1_lat_n1_vld", 32'(out_vld), 32'd1);
                chk("t1_lat_n1_data", 32'({out_parity, out_data}), 32'(t1[0].exp));
            end
        end
        wait_done("t1", 40);
        chk("t1_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("t1_out%0d", i), 32'(got[i]), 32'(t1[i].exp));
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt), 32'd1);

        // Three passes of constant 10: nothing until the last pass
        start_tile(2, 3);
        for (int p = 0; p < 3; p++) begin
            smp(2'b01, 16'd10);
            smp(2'b10, 16'd10);
            smp(2'b01, 16'd10);
            smp(2'b10, 16'd10);
            if (p < 2) begin
                tick();
                chk($sformatf("t2_quiet_pass%0d", p), 32'(got.size() + 32'(out_vld)), 32'd0);
            end
        end
        exp_q = '{{1'b0, 16'd30}, {1'b1, 16'd30}, {1'b0, 16'd30}, {1'b1, 16'd30}};
        wait_done("t2", 40);
        cmp_q("t2");

        // Overflow: consumer stalled for 16 final results into an 8-deep FIFO
        out_rdy = 1'b0;
        start_tile(8, 1);
        for (int k = 1; k <= 8; k++) begin
            smp(2'b01, 16'(k));
            smp(2'b10, 16'(100 + k));
        end
        tick();
        tick();
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_no_done_while_full", 32'(done_cnt), 32'd0);
        chk("t3_busy_flush", 32'(busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back({1'b0, 16'(k)});
            exp_q.push_back({1'b1, 16'(100 + k)});
        end
        out_rdy = 1'b1;
        wait_done("t3", 40);
        cmp_q("t3");
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);

        // Illegal both-valid sample mid-row
        start_tile(2, 1);
        chk("t4_ovf_cleared", 32'(ovf), 32'd0);
        smp(2'b01, 16'd100);
        smp(2'b11, 16'd999);
        tick();
        chk("t4_err", 32'(err), 32'd1);
        smp(2'b01, 16'd200);
        smp(2'b10, 16'd300);
        smp(2'b10, 16'd400);
        exp_q = '{{1'b0, 16'd100}, {1'b0, 16'd200}, {1'b1, 16'd300}, {1'b1, 16'd400}};
        wait_done("t4", 40);
        cmp_q("t4");

        // Negative final sum: 3 + (-8)
        start_tile(1, 2);
        chk("t5_err_cleared", 32'(err), 32'd0);
        smp(2'b01, 16'd3);
        smp(2'b10, 16'd7);
        smp(2'b01, 16'hFFF8);
        smp(2'b10, 16'd1);
`ifdef DCNN_PSUM_RELU_EN
        exp_q = '{{1'b0, 16'h0000}, {1'b1, 16'd8}};
`else
        exp_q = '{{1'b0, 16'hFFFB}, {1'b1, 16'd8}};
`endif
        wait_done("t5", 40);
        cmp_q("t5");

        // Reset during pass 2, then a fresh tile
        start_tile(2, 3);
        smp(2'b01, 16'd1);
        smp(2'b10, 16'd2);
        smp(2'b01, 16'd3);
        smp(2'b10, 16'd4);
        smp(2'b01, 16'd5);
        chk("t6_busy_before", 32'(busy), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_out_vld", 32'(out_vld), 32'd0);
        chk("t6_rst_out_data", 32'(out_data), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        start_tile(1, 1);
        smp(2'b10, 16'd9);
        smp(2'b01, 16'd7);
        exp_q = '{{1'b1, 16'd9}, {1'b0, 16'd7}};
        wait_done("t6", 40);
        cmp_q("t6");

        // Randomized tiles against a per-position sum model
        rand_rdy = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int rl;
            int np;
            logic [15:0] sum [2][8];
            rl = $urandom_range(1, 8);
            np = $urandom_range(1, 3);
            start_tile(rl, np);
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < 8; i++) sum[p][i] = '0;
            for (int pass = 0; pass < np; pass++) begin
                int rem [2];
                int idx [2];
                rem[0] = rl; rem[1] = rl; idx[0] = 0; idx[1] = 0;
                while (rem[0] + rem[1] > 0) begin
                    int par;
                    int guard;
                    logic [15:0] v;
                    guard = 0;
                    while (exp_q.size() - got.size() >= 6 && guard < 200) begin
                        tick();
                        guard++;
                    end
                    if ($urandom_range(0, 2) == 0) tick();
                    par = (rem[0] == 0) ? 1 : (rem[1] == 0) ? 0 : int'($urandom_range(0, 1));
                    v = 16'($urandom);
                    sum[par][idx[par]] = sum[par][idx[par]] + v;
                    if (pass == np - 1) exp_q.push_back({1'(par), relu(sum[par][idx[par]])});
                    smp(par == 1 ? 2'b10 : 2'b01, v);
                    idx[par]++;
                    rem[par]--;
                end
            end
            wait_done($sformatf("rnd%0d", t), 400);
            cmp_q($sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d_ovf", t), 32'(ovf), 32'd0);
        end
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcnn_s1_psum_collector.md
# dcnn_s1_psum_collector

Receiving end of the stride-1 chain core's partial-sum output. Captures the `psum_out`/`psum_out_vld` stream from the last PE, accumulates partial sums over multiple input-channel passes in per-row buffers, and pushes final output pixels into a small output FIFO with a valid/ready interface toward the writeback path. The chain cannot stall, so the collector never back-pressures its input; overflow is flagged instead.

## Interface
- `DW`, 16, data width of psums and outputs (two's complement)
- `M_BITS`, 10, width of the pass-count configuration
- `ROW_BITS`, 6, log2 of the maximum row length (ROW_MAX = 2^ROW_BITS)
- `FIFO_DEPTH`, 8, output FIFO entries (power of two, ≥2)

- `clk` input 1 — clock
- `arst_n` input 1 — asynchronous active-low reset
- `start` input 1 — one-cycle pulse; latches config, clears counters, FIFO, `ovf`, `err`
- `row_len` input ROW_BITS+1 — output pixels per row, legal 1..ROW_MAX; sampled on `start`
- `num_pass` input M_BITS — input-channel passes, legal 1..2^M_BITS-1; sampled on `start`
- `psum_in` input DW — chain tail psum
- `psum_in_vld` input 2 — bit0 = odd-row sample, bit1 = even-row sample
- `out_data` output DW — head of the FIFO: final pixel
- `out_parity` output 1 — 0 = odd row, 1 = even row
- `out_vld` output 1 — FIFO non-empty
- `out_rdy` input 1 — consumer accepts the head when `out_vld & out_rdy`
- `busy` output 1 — state ≠ IDLE
- `done` output 1 — one-cycle pulse at tile completion
- `ovf` output 1 — sticky: a final result was dropped on a full FIFO
- `err` output 1 — sticky: `psum_in_vld == 2'b11` was seen

## Operation
- States: IDLE → (start) ACCUM → (last pass, both rows complete) FLUSH → (FIFO empty) DONE → IDLE. DONE lasts exactly one cycle and drives `done`=1.
- `start` in any state forces ACCUM with a fresh tile. Pending FIFO contents and buffer contents are discarded.
- Buffers: two arrays (odd, even) of ROW_MAX × DW. A position counter `pos[p]` and a pass counter `pass` are shared per tile. Each parity has its own `pos`.
- On a valid sample of parity p in ACCUM, the sum is `acc = (pass==0) ? psum_in : buf[p][pos[p]] + psum_in`. Addition wraps modulo 2^DW.
  - If `pass < num_pass-1`: `buf[p][pos[p]] <= acc`.
  - Otherwise: push {p, acc} to the FIFO. If the FIFO is full and no pop happens in the same cycle, drop the value and set `ovf`.
- `pos[p]` increments. At `row_len-1` it wraps to 0 and sets `row_done[p]`. Further samples of parity p are ignored while `row_done[p]` is set.
- When both `row_done` are set (including the cycle the second one sets), clear both and increment `pass`. The final pass completing moves the FSM to FLUSH.
- `psum_in_vld==2'b11`: sample ignored, `err` set. Valids outside ACCUM are ignored.
- FIFO: simultaneous push and pop on a full FIFO is legal and loses nothing. Push on empty becomes visible the next cycle.
- Parameters are fixed at elaboration. Out-of-range `row_len`/`num_pass` are undefined.

## Timing
- Reset values: `out_data`=0, `out_parity`=0, `out_vld`=0, `busy`=0, `done`=0, `ovf`=0, `err`=0. State is IDLE and all counters are 0. Buffer contents are don't-care.
- Latency: a final-pass sample at edge N appears at `out_vld` after edge N+1 when the FIFO was empty.
- One sample per cycle accepted. No input back-pressure.
- `busy` rises the cycle after `start`. `done` is high for the cycle after the last FIFO pop.
- Reset asserted mid-tile returns to IDLE immediately. All data is lost and no `done` is produced.

## Configuration
- `DCNN_PSUM_RELU_EN`
  - Defined: a final-pass `acc` with MSB=1 is replaced by 0 before the FIFO push.
  - Undefined: the raw wrapped sum is pushed.
  - Intermediate buffer values are never clamped in either case.

## Structure
- Shared package `dcnn_pkg` holds the FSM state enum (`COL_IDLE`, `COL_ACCUM`, `COL_FLUSH`, `COL_DONE`) and the parity constants `PAR_ODD=0`, `PAR_EVEN=1`.
- One sub-module: `dcnn_sync_fifo`, a parameterised show-ahead FIFO of width DW+1 and depth FIFO_DEPTH, with `full`/`empty` outputs.
- Accumulation datapath and FSM live in the top module.

## Test plan
- row_len=4, num_pass=1, odd 1,2,3,4 interleaved with even 5,6,7,8, out_rdy=1 → 8 outputs in arrival order with correct parity, then `done` pulse, `ovf`=`err`=0.
- row_len=2, num_pass=3, every sample 10 → outputs only in pass 3, each 30. No FIFO activity in passes 1–2.
- FIFO_DEPTH=8, row_len=8, num_pass=1, out_rdy=0 for 16 samples → `ovf`=1. The first 8 values are retained. Raising out_rdy drains exactly 8 entries, then `done`.
- `psum_in_vld=2'b11` mid-row → `err`=1. The counters are unchanged and the next legal sample fills the same position.
- num_pass=2, sums 3 + (−8) → output 0 with `DCNN_PSUM_RELU_EN`, 0xFFFB without.
- Assert `arst_n` during pass 2 → all outputs at reset values. Then `start` with a new config completes normally.
